// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers:
// state encoding, per-boundary bundle widths and the instruction NOP.
package pipe_pkg;

    typedef logic [1:0] pipe_state_t;

    // The encoding doubles as the occupancy count
    localparam pipe_state_t ST_EMPTY = 2'd0;
    localparam pipe_state_t ST_ONE   = 2'd1;
    localparam pipe_state_t ST_FULL  = 2'd2;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 128;
    localparam int EX_MEM_W = 106;
    localparam int MEM_WB_W = 71;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0013;

endpackage

// File: rtl/pipe_dffe.sv
// Enabled register with an optional synchronous clear to a fixed value.
// Clear has priority over enable.
module pipe_dffe #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0,
    parameter bit               CLR_EN  = 1'b1
) (
    input  logic             Clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge Clk) begin
        if (CLR_EN && clr)
            q <= CLR_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer; every output is taken straight from flops or a decode of the state.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held, out_data = BUBBLE
//   ST_ONE   | head entry in main, skid unused
//   ST_FULL  | head in main, next entry in skid, in_ready = 0
module pipe_skid_reg #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    import pipe_pkg::*;

    pipe_state_t      state, state_nxt;
    logic             in_xfer, out_xfer;
    logic             main_clr, main_en, skid_en;
    logic [WIDTH-1:0] main_d, skid_q;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign count     = state;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        main_clr  = 1'b0;
        main_en   = 1'b0;
        main_d    = in_data;
        skid_en   = 1'b0;
        if (Flush) begin
            // an accepted input this cycle is discarded along with the rest
            state_nxt = ST_EMPTY;
            main_clr  = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_nxt = ST_ONE;
                        main_en   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = ST_FULL;
                        skid_en   = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = ST_EMPTY;
                        main_clr  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_nxt = ST_ONE;
                        main_en   = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    main_clr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    pipe_dffe #(.WIDTH(WIDTH), .CLR_VAL(BUBBLE), .CLR_EN(1'b1)) u_main (
        .Clk (Clk),
        .clr (Rst | main_clr),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    // skid contents are don't-care whenever it is not the second entry
    pipe_dffe #(.WIDTH(WIDTH), .CLR_VAL('0), .CLR_EN(1'b0)) u_skid (
        .Clk (Clk),
        .clr (1'b0),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed 32-bit scenarios plus a 7-bit random soak,
// both compared every cycle against a queue model of the stage.
module tb_pipe_skid_reg;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // 32-bit instance (default BUBBLE = 0)
    logic        a_rst = 1'b1, a_flush = 1'b0, a_ivalid = 1'b0, a_ordy = 1'b0;
    logic [31:0] a_idata = '0;
    logic        a_irdy, a_ovalid;
    logic [31:0] a_odata;
    logic [1:0]  a_count;

    // 7-bit instance with a non-zero bubble
    logic        b_rst = 1'b1, b_flush = 1'b0, b_ivalid = 1'b0, b_ordy = 1'b0;
    logic [6:0]  b_idata = '0;
    logic        b_irdy, b_ovalid;
    logic [6:0]  b_odata;
    logic [1:0]  b_count;

    pipe_skid_reg #(.WIDTH(32)) dut_a (
        .Clk(Clk), .Rst(a_rst), .Flush(a_flush),
        .in_valid(a_ivalid), .in_ready(a_irdy), .in_data(a_idata),
        .out_valid(a_ovalid), .out_ready(a_ordy), .out_data(a_odata),
        .count(a_count)
    );

    pipe_skid_reg #(.WIDTH(7), .BUBBLE(7'h13)) dut_b (
        .Clk(Clk), .Rst(b_rst), .Flush(b_flush),
        .in_valid(b_ivalid), .in_ready(b_irdy), .in_data(b_idata),
        .out_valid(b_ovalid), .out_ready(b_ordy), .out_data(b_odata),
        .count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two entries; head is the visible output
    logic [31:0] qa[$];
    logic [6:0]  qb[$];
    bit a_started = 0, b_started = 0;
    int b_delivered = 0, b_accepted = 0, b_flushed = 0;

    always @(posedge Clk) begin
        bit acc, del;
        cyc++;
        if (a_rst) begin
            qa.delete();
            a_started = 1;
        end else if (a_started) begin
            acc = a_ivalid && (qa.size() < 2);
            del = a_ordy && (qa.size() > 0);
            if (del) void'(qa.pop_front());
            if (a_flush) qa.delete();
            else if (acc) qa.push_back(a_idata);
        end
        if (b_rst) begin
            qb.delete();
            b_started = 1;
        end else if (b_started) begin
            acc = b_ivalid && (qb.size() < 2);
            del = b_ordy && (qb.size() > 0);
            if (del) begin
                void'(qb.pop_front());
                b_delivered++;
            end
            if (acc) b_accepted++;
            if (a_flush || b_flush) begin
                if (b_flush) begin
                    b_flushed += qb.size() + (acc ? 1 : 0);
                    qb.delete();
                end else if (acc) qb.push_back(b_idata);
            end else if (acc) qb.push_back(b_idata);
        end
    end

    // Delivery log of the 32-bit instance, taken from DUT outputs
    logic [31:0] dlog[$];
    int          dcyc[$];
    int          a_maxcount = 0;

    always @(negedge Clk) begin
        if (a_started) begin
            chk("a_out_valid", 32'(a_ovalid), 32'(qa.size() > 0));
            chk("a_in_ready",  32'(a_irdy),   32'(qa.size() < 2));
            chk("a_count",     32'(a_count),  32'(qa.size()));
            chk("a_out_data",  a_odata,       (qa.size() > 0) ? qa[0] : 32'h0);
            if (a_ovalid && a_ordy) begin
                dlog.push_back(a_odata);
                dcyc.push_back(cyc);
            end
            if (int'(a_count) > a_maxcount) a_maxcount = int'(a_count);
        end
        if (b_started) begin
            chk("b_out_valid", 32'(b_ovalid), 32'(qb.size() > 0));
            chk("b_count",     32'(b_count),  32'(qb.size()));
            chk("b_out_data",  32'(b_odata),  32'((qb.size() > 0) ? qb[0] : 7'h13));
            chk("b_in_ready_vs_count", 32'(b_irdy), 32'(b_count != 2'd2));
            if (!b_ovalid) chk("b_bubble", 32'(b_odata), 32'h13);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Holds a_idata offered until accepted, bounded
    task automatic push_a(input logic [31:0] d);
        bit acc;
        int n;
        a_ivalid = 1'b1;
        a_idata  = d;
        acc = 0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = a_irdy;
            step();
            n++;
        end
        a_ivalid = 1'b0;
        if (!acc) chk("push_a_timeout", 32'(acc), 32'h1);
    endtask

    initial begin
        // reset then idle
        step(); step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        step(); step();
        chk("idle_out_valid", 32'(a_ovalid), 32'h0);
        chk("idle_in_ready",  32'(a_irdy),   32'h1);
        chk("idle_count",     32'(a_count),  32'h0);
        chk("idle_out_data",  a_odata,       32'h0);

        // streaming
        dlog.delete(); dcyc.delete(); a_maxcount = 0;
        a_ordy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_ivalid = 1'b1;
            a_idata  = 32'(i);
            step();
            if (i == 1) chk("stream_latency", a_odata, 32'h1);
        end
        a_ivalid = 1'b0;
        step(); step();
        chk("stream_len", 32'(dlog.size()), 32'd16);
        for (int i = 0; i < dlog.size() && i < 16; i++)
            chk("stream_order", dlog[i], 32'(i + 1));
        chk("stream_back_to_back", 32'(dcyc[15] - dcyc[0]), 32'd15);
        chk("stream_maxcount", 32'(a_maxcount), 32'd1);

        // backpressure
        dlog.delete(); dcyc.delete();
        a_ordy = 1'b0;
        push_a(32'hA);
        push_a(32'hB);
        a_ivalid = 1'b1;
        a_idata  = 32'hC;
        step(); step(); step();
        chk("bp_count",    32'(a_count), 32'd2);
        chk("bp_in_ready", 32'(a_irdy),  32'd0);
        chk("bp_head",     a_odata,      32'hA);
        a_ordy = 1'b1;
        push_a(32'hC);
        step(); step();
        chk("bp_len", 32'(dlog.size()), 32'd3);
        if (dlog.size() == 3) begin
            chk("bp_out0", dlog[0], 32'hA);
            chk("bp_out1", dlog[1], 32'hB);
            chk("bp_out2", dlog[2], 32'hC);
            chk("bp_gap1", 32'(dcyc[1] - dcyc[0]), 32'd1);
            chk("bp_gap2", 32'(dcyc[2] - dcyc[1]), 32'd1);
        end

        // flush while full, with input offered
        a_ordy = 1'b0;
        push_a(32'h11);
        push_a(32'h22);
        dlog.delete();
        a_flush  = 1'b1;
        a_ivalid = 1'b1;
        a_idata  = 32'h33;
        step();
        a_flush  = 1'b0;
        a_ivalid = 1'b0;
        chk("flush_count",     32'(a_count),  32'd0);
        chk("flush_out_valid", 32'(a_ovalid), 32'd0);
        chk("flush_out_data",  a_odata,       32'h0);
        a_ordy = 1'b1;
        step(); step(); step();
        chk("flush_nothing_out", 32'(dlog.size()), 32'd0);

        // flush in the same cycle as a delivery
        a_ordy = 1'b0;
        push_a(32'h55);
        dlog.delete();
        a_ordy  = 1'b1;
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        step(); step();
        chk("flushdel_len", 32'(dlog.size()), 32'd1);
        if (dlog.size() == 1) chk("flushdel_data", dlog[0], 32'h55);
        chk("flushdel_count", 32'(a_count), 32'd0);

        // reset while full
        a_ordy = 1'b0;
        push_a(32'h66);
        push_a(32'h77);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        chk("rst_full_count",    32'(a_count), 32'd0);
        chk("rst_full_out_data", a_odata,      32'h0);
        chk("rst_full_in_ready", 32'(a_irdy),  32'd1);

        // random soak on the 7-bit instance
        for (int i = 0; i < 10000; i++) begin
            b_ivalid = ($urandom_range(0, 3) != 0);
            b_idata  = 7'($urandom);
            b_ordy   = ($urandom_range(0, 2) != 0);
            b_flush  = ($urandom_range(0, 63) == 0);
            b_rst    = ($urandom_range(0, 999) == 0);
            step();
        end
        b_ivalid = 1'b0;
        b_flush  = 1'b0;
        b_rst    = 1'b0;
        b_ordy   = 1'b1;
        step(); step(); step();
        chk("soak_drained", 32'(b_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
